// File: rtl/ide_ctrl_mc_if.sv
// 68000-side bus and IDE/ROM-side signals of the multi-channel IDE controller.
interface ide_ctrl_mc_if #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned BANK_BITS = 2
);
  logic [23:1]            ADDR;
  logic [BANK_BITS-1:0]   DIN;
  logic                   AS_n;
  logic                   UDS_n;
  logic                   LDS_n;
  logic                   RW;
  logic                   ide_access;
  logic                   ide_enable;
  logic                   DTACK_n;
  logic                   IOR_n;
  logic                   IOW_n;
  logic [2*CHANNELS-1:0]  CS_n;
  logic [BANK_BITS-1:0]   ROM_BANK;
  logic                   IDE_ROMEN;
  logic                   busy;

  modport slave (
    input  ADDR, DIN, AS_n, UDS_n, LDS_n, RW, ide_access, ide_enable,
    output DTACK_n, IOR_n, IOW_n, CS_n, ROM_BANK, IDE_ROMEN, busy
  );

  modport master (
    output ADDR, DIN, AS_n, UDS_n, LDS_n, RW, ide_access, ide_enable,
    input  DTACK_n, IOR_n, IOW_n, CS_n, ROM_BANK, IDE_ROMEN, busy
  );
endinterface

// File: rtl/ide_ctrl_mc.sv
// Zorro II IDE controller: decodes 68000 cycles into IDE chip selects and
// timed IOR/IOW strobes, plus DTACK, boot-ROM enable and ROM bank register.
module ide_ctrl_mc #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned BANK_BITS = 2,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned RD_CYC    = 3,
  parameter int unsigned WR_CYC    = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic          CLK,
  input  logic          RESET_n,
  ide_ctrl_mc_if.slave  bus
);

  localparam int unsigned NCS = 2 * CHANNELS;
  localparam int unsigned CW  = 4;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_q, rd_d;
  logic [NCS-1:0]  cs_sel_q, cs_sel_d;
  logic [NCS-1:0]  cs_q, cs_d;
  logic            ior_q, ior_d;
  logic            iow_q, iow_d;
  logic            dtack_q, dtack_d;
  logic            busy_q;
  logic            ide_en_q;
  logic [BANK_BITS-1:0] bank_q;

  logic [1:0]      ch;
  logic            ch_ok;
  logic            as_low;
  logic            reg_rgn;
  logic            bank_rgn;
  logic            wr_strobe;
  logic            fsm_hit;
  logic            rom_cyc;
  logic            start;
  logic [NCS-1:0]  cs_hit;
  logic            unused_bits;

  assign unused_bits = ^{bus.LDS_n, bus.ADDR[23:17], bus.ADDR[11:1]};

  // Address decode: region, channel field and one-hot chip select
  always_comb begin
    ch        = bus.ADDR[13:12];
    ch_ok     = (ch != 2'd0) && (32'(ch) <= CHANNELS);
    as_low    = ~bus.AS_n;
    reg_rgn   = (bus.ADDR[16:15] == 2'b00);
    bank_rgn  = (bus.ADDR[16:15] == 2'b01);
    wr_strobe = as_low & bus.ide_access & ~bus.RW & ~bus.UDS_n;
    fsm_hit   = bus.ide_access & ide_en_q & reg_rgn & ch_ok;
    cs_hit    = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (32'(ch) == 32'(k + 1)) begin
        cs_hit[2*k]   = ~bus.ADDR[14];
        cs_hit[2*k+1] = bus.ADDR[14];
      end
    end
  end

  // Card enable flag and ROM bank register, written through the upper byte lane
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ide_en_q <= 1'b0;
      bank_q   <= '0;
    end else begin
      if (wr_strobe && reg_rgn && bus.ide_enable)  ide_en_q <= 1'b1;
      if (wr_strobe && bank_rgn && bus.ide_enable) bank_q   <= bus.DIN;
    end
  end

  // FSM state, counter and registered strobes
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      cs_sel_q <= '0;
      cs_q     <= '0;
      ior_q    <= 1'b0;
      iow_q    <= 1'b0;
      dtack_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      cs_sel_q <= cs_sel_d;
      cs_q     <= cs_d;
      ior_q    <= ior_d;
      iow_q    <= iow_d;
      dtack_q  <= dtack_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  // Next state; timed states leave when cnt reaches its last-cycle value
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    if (state_q != IDLE && bus.AS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (as_low && fsm_hit) begin
            start = 1'b1;
            if (SETUP_CYC == 0) begin
              state_d = STROBE;
              cnt_d   = bus.RW ? CW'(RD_CYC) : CW'(WR_CYC);
            end else begin
              state_d = SETUP;
              cnt_d   = CW'(SETUP_CYC - 1);
            end
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_d = STROBE;
            cnt_d   = rd_q ? CW'(RD_CYC) : CW'(WR_CYC);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        STROBE: begin
          if (cnt_q == CW'(1)) begin
            if (rd_q || HOLD_CYC == 0) begin
              state_d = DONE;
            end else begin
              state_d = HOLD;
              cnt_d   = CW'(HOLD_CYC - 1);
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output next-values derived from the upcoming state
  always_comb begin
    rd_d     = start ? bus.RW : rd_q;
    cs_sel_d = start ? cs_hit : cs_sel_q;
    rom_cyc  = as_low & bus.ide_access & ~fsm_hit & (state_q == IDLE);
    cs_d     = (state_d != IDLE) ? cs_sel_d : '0;
    ior_d    = rd_d & ((state_d == STROBE) | (state_d == DONE));
    iow_d    = ~rd_d & (state_d == STROBE);
    dtack_d  = (state_d == DONE) | rom_cyc;
  end

  // IDE strobes drop the moment AS_n rises; ROM side is forced idle in reset
  assign bus.DTACK_n   = ~dtack_q;
  assign bus.IOR_n     = ~ior_q | bus.AS_n;
  assign bus.IOW_n     = ~iow_q | bus.AS_n;
  assign bus.CS_n      = ~cs_q | {NCS{bus.AS_n}};
  assign bus.busy      = busy_q;
  assign bus.IDE_ROMEN = ~(RESET_n & as_low & bus.ide_access &
                           (~ide_en_q | ~ch_ok | bus.ADDR[16]));
  assign bus.ROM_BANK  = !RESET_n ? '0 :
                         (ide_en_q ? bank_q : BANK_BITS'(bus.ADDR[16]));

endmodule

// File: tb/tb_ide_ctrl_mc.sv
// Self-checking bench for ide_ctrl_mc: vector table through a scoreboard,
// plus abort and mid-cycle reset sequences.
module tb_ide_ctrl_mc;

  localparam int unsigned CH  = 2;
  localparam int unsigned BB  = 2;
  localparam int unsigned S   = 1;
  localparam int unsigned R   = 3;
  localparam int unsigned W   = 2;
  localparam int unsigned H   = 1;
  localparam int unsigned NCS = 2 * CH;
  localparam int RDL = 4;   // SETUP + RD edges after edge n
  localparam int WRL = 4;   // SETUP + WR + HOLD edges after edge n
  localparam int WIN = 12;
  localparam int NV  = 22;

  logic CLK = 1'b0;
  logic RESET_n = 1'b0;

  ide_ctrl_mc_if #(.CHANNELS(CH), .BANK_BITS(BB)) bus ();

  ide_ctrl_mc #(
    .CHANNELS(CH), .BANK_BITS(BB), .SETUP_CYC(S),
    .RD_CYC(R), .WR_CYC(W), .HOLD_CYC(H)
  ) dut (
    .CLK(CLK),
    .RESET_n(RESET_n),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [23:0]    a;
    logic           rw;
    logic [BB-1:0]  din;
    logic           uds;
    logic           acc;
    logic           en;
    int             lat;
    logic [NCS-1:0] cs;
    int             ior;
    int             iow;
    logic           romen;
    logic [BB-1:0]  bank;
  } vec_t;

  typedef struct {
    int             lat;
    logic [NCS-1:0] cs;
    int             ior;
    int             iow;
    logic           romen;
    logic [BB-1:0]  bank;
  } exp_t;

  vec_t vt [NV];
  exp_t sb [$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [23:0] a, input logic rw, input logic [BB-1:0] din,
                       input logic uds, input logic acc, input logic en);
    bus.ADDR       = a[23:1];
    bus.RW         = rw;
    bus.DIN        = din;
    bus.UDS_n      = uds;
    bus.LDS_n      = uds;
    bus.ide_access = acc;
    bus.ide_enable = en;
    bus.AS_n       = 1'b0;
  endtask

  task automatic release_bus(input string tag);
    bus.AS_n  = 1'b1;
    bus.UDS_n = 1'b1;
    bus.LDS_n = 1'b1;
    #1;
    chk({tag, ".rel_ior"}, 32'(bus.IOR_n), 32'd1);
    chk({tag, ".rel_iow"}, 32'(bus.IOW_n), 32'd1);
    chk({tag, ".rel_cs"},  32'(bus.CS_n), 32'({NCS{1'b1}}));
    @(posedge CLK); #1;
    chk({tag, ".busy_end"},  32'(bus.busy), 32'd0);
    chk({tag, ".dtack_end"}, 32'(bus.DTACK_n), 32'd1);
  endtask

  task automatic compare(input string tag, input exp_t e, input int lat,
                         input logic [NCS-1:0] seen, input int ior_f, input int iow_c,
                         input logic romen0, input logic [BB-1:0] bank0);
    chk({tag, ".lat"},   32'(lat), 32'(e.lat));
    chk({tag, ".cs"},    32'(seen), 32'(e.cs));
    chk({tag, ".ior"},   32'(ior_f), 32'(e.ior));
    chk({tag, ".iow"},   32'(iow_c), 32'(e.iow));
    chk({tag, ".romen"}, 32'(romen0), 32'(e.romen));
    chk({tag, ".bank"},  32'(bank0), 32'(e.bank));
  endtask

  task automatic run_vec(input int i);
    string tag;
    exp_t e;
    logic [NCS-1:0] seen;
    int ior_f, iow_c;
    logic romen0;
    logic [BB-1:0] bank0;
    bit got;
    tag = $sformatf("v%0d", i);
    drive(vt[i].a, vt[i].rw, vt[i].din, vt[i].uds, vt[i].acc, vt[i].en);
    sb.push_back('{lat: vt[i].lat, cs: vt[i].cs, ior: vt[i].ior, iow: vt[i].iow,
                   romen: vt[i].romen, bank: vt[i].bank});
    #1;
    romen0 = bus.IDE_ROMEN;
    bank0  = bus.ROM_BANK;
    seen = '0; ior_f = -1; iow_c = 0; got = 1'b0;
    for (int k = 0; k < WIN && !got; k++) begin
      @(posedge CLK); #1;
      seen = seen | ~bus.CS_n;
      if (ior_f < 0 && !bus.IOR_n) ior_f = k;
      if (!bus.IOW_n) iow_c++;
      if (!bus.DTACK_n) begin
        got = 1'b1;
        e = sb.pop_front();
        compare(tag, e, k, seen, ior_f, iow_c, romen0, bank0);
      end
    end
    if (!got) begin
      e = sb.pop_front();
      compare(tag, e, -1, seen, ior_f, iow_c, romen0, bank0);
    end
    release_bus(tag);
  endtask

  initial begin
    //          addr         rw    din   uds   acc   en    lat  cs       ior  iow  romen bank
    vt[0]  = '{24'h001000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 0,   4'b0000, -1,  0,   1'b0, 2'd0};
    vt[1]  = '{24'h010000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 0,   4'b0000, -1,  0,   1'b0, 2'd1};
    vt[2]  = '{24'h000000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 0,   4'b0000, -1,  0,   1'b0, 2'd0};
    vt[3]  = '{24'h001000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 0,   4'b0000, -1,  0,   1'b0, 2'd0};
    vt[4]  = '{24'h000000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd0};
    vt[5]  = '{24'h001000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, RDL, 4'b0001, S,   0,   1'b1, 2'd0};
    vt[6]  = '{24'h006000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, WRL, 4'b1000, -1,  W,   1'b1, 2'd0};
    vt[7]  = '{24'h002000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, RDL, 4'b0100, S,   0,   1'b1, 2'd0};
    vt[8]  = '{24'h005000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, WRL, 4'b0010, -1,  W,   1'b1, 2'd0};
    vt[9]  = '{24'h003000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd0};
    vt[10] = '{24'h000000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd0};
    vt[11] = '{24'h008000, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd0};
    vt[12] = '{24'h010000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd2};
    vt[13] = '{24'h011000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd2};
    vt[14] = '{24'h001000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, -1,  4'b0000, -1,  0,   1'b1, 2'd2};
    vt[15] = '{24'h008000, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd2};
    vt[16] = '{24'h010000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd2};
    vt[17] = '{24'h001000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, RDL, 4'b0001, S,   0,   1'b1, 2'd2};
    // after the mid-cycle reset: card disabled again, bank cleared
    vt[18] = '{24'h001000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd0};
    vt[19] = '{24'h000000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd0};
    vt[20] = '{24'h010000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 0,   4'b0000, -1,  0,   1'b0, 2'd0};
    vt[21] = '{24'h005000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, RDL, 4'b0010, S,   0,   1'b1, 2'd0};

    bus.ADDR = '0; bus.DIN = '0; bus.AS_n = 1'b1; bus.UDS_n = 1'b1; bus.LDS_n = 1'b1;
    bus.RW = 1'b1; bus.ide_access = 1'b0; bus.ide_enable = 1'b0;
    #2;
    chk("rst.dtack", 32'(bus.DTACK_n),   32'd1);
    chk("rst.ior",   32'(bus.IOR_n),     32'd1);
    chk("rst.iow",   32'(bus.IOW_n),     32'd1);
    chk("rst.cs",    32'(bus.CS_n),      32'({NCS{1'b1}}));
    chk("rst.romen", 32'(bus.IDE_ROMEN), 32'd1);
    chk("rst.bank",  32'(bus.ROM_BANK),  32'd0);
    chk("rst.busy",  32'(bus.busy),      32'd0);
    repeat (2) @(posedge CLK);
    #1 RESET_n = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i <= 17; i++) run_vec(i);

    // AS_n rises while the strobe is active (read, then write)
    for (int r = 0; r < 2; r++) begin
      string tag;
      bit dt_seen;
      tag = (r == 0) ? "abort_rd" : "abort_wr";
      dt_seen = 1'b0;
      if (r == 0) drive(24'h001000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1);
      else        drive(24'h006000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
      repeat (3) begin
        @(posedge CLK); #1;
        if (!bus.DTACK_n) dt_seen = 1'b1;
      end
      if (r == 0) chk({tag, ".ior_pre"}, 32'(bus.IOR_n), 32'd0);
      else        chk({tag, ".iow_pre"}, 32'(bus.IOW_n), 32'd0);
      bus.AS_n = 1'b1;
      bus.UDS_n = 1'b1;
      #1;
      chk({tag, ".ior"},  32'(bus.IOR_n), 32'd1);
      chk({tag, ".iow"},  32'(bus.IOW_n), 32'd1);
      chk({tag, ".cs"},   32'(bus.CS_n),  32'({NCS{1'b1}}));
      chk({tag, ".busy_pre"}, 32'(bus.busy), 32'd1);
      @(posedge CLK); #1;
      if (!bus.DTACK_n) dt_seen = 1'b1;
      chk({tag, ".busy"},     32'(bus.busy), 32'd0);
      chk({tag, ".no_dtack"}, 32'(dt_seen),  32'd0);
      @(posedge CLK); #1;
    end

    // Reset pulse while a write sits in HOLD
    drive(24'h006000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    repeat (4) begin
      @(posedge CLK); #1;
    end
    chk("hold.busy", 32'(bus.busy),    32'd1);
    chk("hold.iow",  32'(bus.IOW_n),   32'd1);
    chk("hold.cs",   32'(bus.CS_n),    32'b0111);
    chk("hold.dtack", 32'(bus.DTACK_n), 32'd1);
    RESET_n = 1'b0;
    #1;
    chk("mrst.dtack", 32'(bus.DTACK_n),   32'd1);
    chk("mrst.ior",   32'(bus.IOR_n),     32'd1);
    chk("mrst.iow",   32'(bus.IOW_n),     32'd1);
    chk("mrst.cs",    32'(bus.CS_n),      32'({NCS{1'b1}}));
    chk("mrst.romen", 32'(bus.IDE_ROMEN), 32'd1);
    chk("mrst.bank",  32'(bus.ROM_BANK),  32'd0);
    chk("mrst.busy",  32'(bus.busy),      32'd0);
    bus.AS_n = 1'b1;
    bus.UDS_n = 1'b1;
    @(posedge CLK); #1;
    RESET_n = 1'b1;
    @(posedge CLK); #1;

    for (int i = 18; i < NV; i++) run_vec(i);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
